// File: rtl/uart_msg_pkg.sv
// uart_msg_pkg: packet layout, header codes and reply construction for the test harness
package uart_msg_pkg;
    localparam int MSG_WIDTH = 40;
    localparam int HDR_LSB = 0;
    localparam int HDR_MSB = 7;
    localparam int PAY_LSB = 8;
    localparam int PAY_MSB = 39;
    localparam logic [7:0] HDR_SYS_STATUS = 8'h01;
    localparam logic [7:0] HDR_MEM_PARAMS = 8'h02;
    localparam logic [7:0] HDR_REPLACE_NUM = 8'h03;
    localparam int NO_NUMS_LSB = 0;
    localparam int NO_NUMS_MSB = 7;
    localparam int TEST_MODE_BIT = 8;
    localparam int PW_LSB = 12;
    localparam int PW_MSB = 19;
    localparam int PG_LSB = 20;
    localparam int PG_MSB = 27;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 7;
    localparam int VAL_LSB = 8;
    localparam int VAL_MSB = 15;
    localparam logic [7:0] REPLY_FLAG = 8'h80;
    localparam logic [7:0] ERR_HEADER = 8'hFF;

    typedef struct packed {
        logic [PAY_MSB-PAY_LSB:0] payload;
        logic [HDR_MSB-HDR_LSB:0] header;
    } msg_t;

    function automatic msg_t make_reply(input msg_t m);
        msg_t r;
        logic known;
        known = (m.header == HDR_SYS_STATUS) || (m.header == HDR_MEM_PARAMS) || (m.header == HDR_REPLACE_NUM);
        r.header = known ? (m.header | REPLY_FLAG) : ERR_HEADER;
        r.payload = (m.header == HDR_SYS_STATUS) ? {31'b0, m.payload[0]} : known ? m.payload : 32'b0;
        return r;
    endfunction
endpackage

// File: rtl/test_harness_uart.sv
// test_harness_uart: byte-level 8N1 UART receiver and transmitter
module test_harness_uart #(
    parameter int CLKS_PER_BAUD = 1250
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx_pin,
    output logic       tx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);
    localparam int CW = $clog2(CLKS_PER_BAUD + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BAUD - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BAUD / 2 - 1);
    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA = 2'd2;
    localparam logic [1:0] RX_STOP = 2'd3;

    logic [2:0]    rx_sync;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [9:0]    tx_shift;
    logic [3:0]    tx_n;
    logic          tx_busy;
    logic [CW-1:0] tx_cnt;

    assign rx_data = rx_shift;
    assign tx_ready = !tx_busy;
    assign tx_pin = tx_shift[0];

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rx_sync <= 3'b111;
            rx_state <= RX_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[1:0], rx_pin};
            rx_valid <= 1'b0;
            if (rx_state != RX_IDLE) rx_cnt <= rx_cnt - 1'b1;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_sync[2] && !rx_sync[1]) begin
                        rx_state <= RX_START;
                        rx_cnt <= HALF;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        rx_cnt <= FULL;
                        rx_bit <= '0;
                        rx_state <= rx_sync[1] ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_cnt <= FULL;
                        rx_shift <= {rx_sync[1], rx_shift[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end
                end
                default: begin
                    if (rx_cnt == '0) begin
                        rx_valid <= rx_sync[1];
                        rx_state <= RX_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            tx_shift <= '1;
            tx_n <= '0;
            tx_busy <= 1'b0;
            tx_cnt <= '0;
        end else if (!tx_busy) begin
            if (tx_valid) begin
                tx_shift <= {1'b1, tx_data, 1'b0};
                tx_n <= '0;
                tx_busy <= 1'b1;
                tx_cnt <= FULL;
            end
        end else if (tx_cnt == '0) begin
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_cnt <= FULL;
            tx_n <= tx_n + 4'd1;
            if (tx_n == 4'd9) tx_busy <= 1'b0;
        end else begin
            tx_cnt <= tx_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/test_harness_top.sv
// test_harness_top: UART command harness driving the number store and led pulse sequencer
module test_harness_top
    import uart_msg_pkg::*;
#(
    parameter int CLK_RATE = 12_000_000,
    parameter int BAUD = 9600,
    parameter int NUM_DEPTH = 32,
    parameter int BYTE_TIMEOUT = 24_000
) (
    input  logic clk,
    input  logic n_reset,
    input  logic uart_rx_pin,
    output logic uart_tx_pin,
    output logic led0,
    output logic led1
);
    localparam int CLKS_PER_BAUD = CLK_RATE / BAUD;
    localparam int AW = $clog2(NUM_DEPTH);
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);

    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [2:0]           byte_cnt;
    logic [31:0]          msg_buf;
    logic [TW-1:0]        idle_cnt;
    logic                 pkt_valid;
    msg_t                 pkt;
    msg_t                 reply;
    logic [MSG_WIDTH-1:0] reply_sh;
    logic [MSG_WIDTH-1:0] pend;
    logic [2:0]           reply_cnt;
    logic                 pend_valid;
    logic                 fire;
    logic                 run;
    logic                 test_mode;
    logic [7:0]           no_nums;
    logic [7:0]           pulse_width;
    logic [7:0]           pulse_gap;
    logic [7:0]           store [NUM_DEPTH];
    logic                 wr_en;
    logic                 seq_on;
    logic [AW-1:0]        seq_addr;
    logic [2:0]           slot;
    logic [8:0]           t;
    logic [7:0]           word;
    logic [7:0]           cur_width;
    logic [7:0]           cur_gap;
    logic [8:0]           lim;
    logic [8:0]           addr_inc;
    logic [AW-1:0]        nxt_addr;
    logic [7:0]           nw;
    logic [8:0]           t_inc;
    logic                 slot_end;

    test_harness_uart #(.CLKS_PER_BAUD(CLKS_PER_BAUD)) u_uart (
        .clk      (clk),
        .n_reset  (n_reset),
        .rx_pin   (uart_rx_pin),
        .tx_pin   (uart_tx_pin),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    assign pkt_valid = rx_valid && (byte_cnt == 3'd4);
    assign pkt = {rx_data, msg_buf};
    assign reply = make_reply(pkt);
    assign wr_en = pkt_valid && (pkt.header == HDR_REPLACE_NUM) &&
                   ({1'b0, pkt.payload[ADDR_MSB:ADDR_LSB]} < 9'(NUM_DEPTH));
    assign tx_valid = reply_cnt != 3'd0;
    assign tx_data = reply_sh[7:0];
    assign fire = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            byte_cnt <= '0;
            msg_buf <= '0;
            idle_cnt <= '0;
        end else if (rx_valid) begin
            msg_buf <= {rx_data, msg_buf[31:8]};
            byte_cnt <= (byte_cnt == 3'd4) ? 3'd0 : byte_cnt + 3'd1;
            idle_cnt <= '0;
        end else if (byte_cnt != 3'd0) begin
            idle_cnt <= (idle_cnt == TW'(BYTE_TIMEOUT - 1)) ? '0 : idle_cnt + 1'b1;
            if (idle_cnt == TW'(BYTE_TIMEOUT - 1)) byte_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            run <= 1'b0;
            test_mode <= 1'b0;
            no_nums <= '0;
            pulse_width <= '0;
            pulse_gap <= '0;
            store <= '{default: 8'h00};
        end else if (pkt_valid) begin
            if (pkt.header == HDR_SYS_STATUS) run <= pkt.payload[0];
            if (pkt.header == HDR_MEM_PARAMS) begin
                no_nums <= pkt.payload[NO_NUMS_MSB:NO_NUMS_LSB];
                test_mode <= pkt.payload[TEST_MODE_BIT];
                pulse_width <= pkt.payload[PW_MSB:PW_LSB];
                pulse_gap <= pkt.payload[PG_MSB:PG_LSB];
            end
            if (wr_en) store[pkt.payload[AW-1:0]] <= pkt.payload[VAL_MSB:VAL_LSB];
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            reply_sh <= '1;
            pend <= '0;
            reply_cnt <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (reply_cnt == 3'd0 && pend_valid) begin
                reply_sh <= pend;
                reply_cnt <= 3'd5;
                pend_valid <= 1'b0;
            end else if (fire) begin
                reply_sh <= {8'h00, reply_sh[MSG_WIDTH-1:8]};
                reply_cnt <= reply_cnt - 3'd1;
            end
            if (pkt_valid) begin
                if (reply_cnt == 3'd0 && !pend_valid) begin
                    reply_sh <= reply;
                    reply_cnt <= 3'd5;
                end else if (!pend_valid || reply_cnt == 3'd0) begin
                    pend <= reply;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    assign lim = ({1'b0, no_nums} > 9'(NUM_DEPTH)) ? 9'(NUM_DEPTH) : {1'b0, no_nums};
    assign addr_inc = 9'(seq_addr) + 9'd1;
    assign nxt_addr = (addr_inc >= lim) ? '0 : addr_inc[AW-1:0];
    assign nw = test_mode ? 8'(nxt_addr) : store[nxt_addr];
    assign t_inc = t + 9'd1;
    assign slot_end = t_inc >= ({1'b0, cur_width} + {1'b0, cur_gap});

    always_ff @(posedge clk) begin
        if (!n_reset || !run) begin
            seq_on <= 1'b0;
            seq_addr <= '0;
            slot <= '0;
            t <= '0;
            word <= '0;
            cur_width <= '0;
            cur_gap <= '0;
        end else if (!seq_on) begin
            if (no_nums != 8'd0) begin
                seq_on <= 1'b1;
                seq_addr <= '0;
                slot <= '0;
                t <= '0;
                word <= test_mode ? 8'h00 : store[0];
                cur_width <= pulse_width;
                cur_gap <= pulse_gap;
            end
        end else if (!slot_end) begin
            t <= t_inc;
        end else begin
            t <= '0;
            slot <= slot + 3'd1;
            if (slot == 3'd7) begin
                seq_on <= no_nums != 8'd0;
                seq_addr <= nxt_addr;
                word <= nw;
                cur_width <= pulse_width;
                cur_gap <= pulse_gap;
            end
        end
    end

    assign led0 = run;
    assign led1 = run && seq_on && word[slot] && (t < {1'b0, cur_width});
endmodule

// File: tb/tb_test_harness_top.sv
// tb_test_harness_top: scoreboard bench for the UART command harness
module tb_test_harness_top;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic uart_rx_pin = 1'b1;
    logic uart_tx_pin;
    logic led0;
    logic led1;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    test_harness_top #(.CLK_RATE(16), .BAUD(1), .NUM_DEPTH(32), .BYTE_TIMEOUT(400)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .uart_rx_pin (uart_rx_pin),
        .uart_tx_pin (uart_tx_pin),
        .led0        (led0),
        .led1        (led1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] model_reply(input logic [39:0] m);
        case (m[7:0])
            8'h01: return {31'b0, m[8], 8'h81};
            8'h02: return {m[39:8], 8'h82};
            8'h03: return {m[39:8], 8'h83};
            default: return {32'b0, 8'hFF};
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx_pin = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_pin = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx_pin = stop;
        repeat (CPB) @(negedge clk);
        uart_rx_pin = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [39:0] m, input int bad);
        for (int i = 0; i < 5; i++) send_byte(m[8*i +: 8], i != bad);
    endtask

    task automatic send_cmd(input logic [39:0] m);
        logic [39:0] r;
        r = model_reply(m);
        for (int i = 0; i < 5; i++) exp_q.push_back(r[8*i +: 8]);
        send_pkt(m, -1);
    endtask

    task automatic wait_replies(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("replies_drained", exp_q.size(), 0);
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic wait_rise(output int at, input int bound);
        logic prev;
        int n = 0;
        logic found = 1'b0;
        prev = led1;
        at = 0;
        while (!found && n < bound) begin
            @(negedge clk);
            n++;
            if (!prev && led1) begin
                found = 1'b1;
                at = cyc;
            end
            prev = led1;
        end
        check("led1_rise", found, 1);
    endtask

    initial begin : tx_monitor
        logic [7:0] b;
        logic stop;
        forever begin
            @(negedge clk);
            if (uart_tx_pin === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx_pin;
                end
                repeat (CPB) @(negedge clk);
                stop = uart_tx_pin;
                check("tx_stop", stop, 1);
                if (exp_q.size() == 0) check("tx_extra_byte", {24'b0, b}, 32'h100);
                else check("tx_byte", b, exp_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #(1_000_000);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int highs;
        int e0, e1, e2, hl;
        logic lv [192];
        logic [7:0] exp_word;
        repeat (5) @(negedge clk);
        check("reset_tx_pin", uart_tx_pin, 1);
        check("reset_led0", led0, 0);
        check("reset_led1", led1, 0);
        n_reset = 1'b1;
        repeat (20) @(negedge clk);

        send_cmd({32'h00C0C005, 8'h02});
        wait_replies(3000);
        check("led0_idle", led0, 0);

        send_cmd({32'h00000001, 8'h01});
        wait_replies(3000);
        check("led0_run", led0, 1);
        highs = 0;
        repeat (960) begin
            @(negedge clk);
            if (led1) highs++;
        end
        check("store_zero_quiet", highs, 0);

        send_cmd({32'h0000A500, 8'h03});
        send_cmd({32'h0000FF20, 8'h03});
        wait_replies(4000);
        exp_word = 8'hA5;
        wait_rise(e0, 2500);
        lv[0] = led1;
        for (int j = 1; j < 192; j++) begin
            @(negedge clk);
            lv[j] = led1;
        end
        for (int k = 0; k < 8; k++)
            check($sformatf("a5_slot%0d", k),
                  {28'b0, lv[24*k], lv[24*k+11], lv[24*k+12], lv[24*k+20]},
                  {28'b0, exp_word[k], exp_word[k], 2'b00});

        send_cmd({32'h00C0C103, 8'h02});
        wait_replies(3000);
        repeat (300) @(negedge clk);
        wait_rise(e0, 1500);
        hl = 0;
        while (led1 && hl < 100) begin
            hl++;
            @(negedge clk);
        end
        check("tm_high_len", hl, 12);
        wait_rise(e1, 1500);
        wait_rise(e2, 1500);
        check("tm_period", e2 - e0, 576);
        check("tm_interval", ((e1 - e0) == 216) || ((e1 - e0) == 360), 1);

        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (600) @(negedge clk);
        send_cmd({32'h00000001, 8'h01});
        wait_replies(3000);
        repeat (300) @(negedge clk);
        check("partial_led0", led0, 1);

        send_cmd({32'h12345678, 8'h55});
        wait_replies(3000);

        send_pkt({32'h00000000, 8'h01}, 2);
        repeat (800) @(negedge clk);
        check("badstop_led0", led0, 1);

        send_cmd({32'h00000000, 8'h01});
        wait_replies(3000);
        check("stop_led0", led0, 0);
        highs = 0;
        repeat (300) begin
            @(negedge clk);
            if (led1) highs++;
        end
        check("stop_led1_quiet", highs, 0);

        repeat (100) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
